seq_alu: RTL and testbench

Multi-cycle, parametrised successor to the CPU's combinational ALU. Executes 8-bit and 16-bit arithmetic/logic operations on a `DATA_W`-bit slice datapath, chaining wide operations low slice first with a registered inter-slice carry. Sits between the decode/control FSM and the register file, with a valid/ready handshake on both sides. All GameBoy flag semantics, including the 16-bit `ADD HL,rr` and `ADD SP,e` rules, are produced in hardware.

---
 rtl/seq_alu_pkg.sv | 47 ++++
 rtl/seq_alu_if.sv | 32 +++
 rtl/seq_alu_slice.sv | 36 +++
 rtl/seq_alu.sv | 217 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        ADC   = 4'd1,
        SUB   = 4'd2,
        SBC   = 4'd3,
        AND   = 4'd4,
        OR    = 4'd5,
        XOR   = 4'd6,
        CP    = 4'd7,
        INC   = 4'd8,
        DEC   = 4'd9,
        ADDW  = 4'd10,
        ADDSP = 4'd11,
        INCW  = 4'd12,
        DECW  = 4'd13
    } seq_alu_op_t;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_H = 1;
    localparam int FLG_C = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_alu_state_t;

    // Word ops walk all slices; everything else (including undefined codes) takes one.
    function automatic logic is_word_op(seq_alu_op_t op);
        return (op == ADDW) || (op == ADDSP) || (op == INCW) || (op == DECW);
    endfunction

    function automatic logic [3:0] pack_flags(logic z, logic n, logic h, logic c);
        logic [3:0] f;
        f        = '0;
        f[FLG_Z] = z;
        f[FLG_N] = n;
        f[FLG_H] = h;
        f[FLG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bus between the control FSM, the ALU and the register file.
interface seq_alu_if #(
    parameter int DATA_W = 8,
    parameter int NSLICE = 2
);
    import seq_alu_pkg::*;

    localparam int WORD_W = DATA_W * NSLICE;

    logic              in_valid;
    logic              in_ready;
    seq_alu_op_t       op_code;
    logic [WORD_W-1:0] op_A;
    logic [WORD_W-1:0] op_B;
    logic [3:0]        curr_flags;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] result;
    logic [3:0]        next_flags;
    logic              op_err;

    modport master (
        output in_valid, op_code, op_A, op_B, curr_flags, out_ready,
        input  in_ready, out_valid, result, next_flags, op_err
    );

    modport slave (
        input  in_valid, op_code, op_A, op_B, curr_flags, out_ready,
        output in_ready, out_valid, result, next_flags, op_err
    );

endinterface

// File: rtl/seq_alu_slice.sv
// One DATA_W-bit add/subtract slice with carry/borrow and half-carry outputs.
module alu_slice #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              hout,
    output logic              hw_out
);

    logic [DATA_W:0]   full;
    logic [4:0]        nib;
    logic [DATA_W-4:0] upper_h;

    // Full-width, bit-3 and bit-(DATA_W-5) adds; in subtract mode the top bit is the borrow.
    always_comb begin
        if (sub) begin
            full    = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, cin};
            nib     = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, cin};
            upper_h = {1'b0, a[DATA_W-5:0]} - {1'b0, b[DATA_W-5:0]} - {{(DATA_W-4){1'b0}}, cin};
        end else begin
            full    = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
            nib     = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
            upper_h = {1'b0, a[DATA_W-5:0]} + {1'b0, b[DATA_W-5:0]} + {{(DATA_W-4){1'b0}}, cin};
        end
        sum    = full[DATA_W-1:0];
        cout   = full[DATA_W];
        hout   = nib[4];
        hw_out = upper_h[DATA_W-4];
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle byte/word ALU: one slice per cycle, low slice first, GameBoy flags.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NSLICE = 2
) (
    input  logic        clk,
    input  logic        rst,
    seq_alu_if.slave    bus
);

    localparam int WORD_W = DATA_W * NSLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    seq_alu_state_t    state_q, state_d;
    seq_alu_op_t       op_q, op_d;
    logic [WORD_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic [3:0]        fin_q, fin_d, flags_q, flags_d;
    logic              sub_q, sub_d, carry_q, carry_d;
    logic              lo_h_q, lo_h_d, lo_c_q, lo_c_d, err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [WORD_W-1:0] eff_a, eff_b;
    logic              eff_sub, eff_cin;

    logic [DATA_W-1:0] s_sum;
    logic              s_cout, s_hout, s_hwout;

    logic [WORD_W-1:0] fin_res;
    logic [3:0]        fin_flags;
    logic              fin_err, last_slice, lo_h, lo_c;
    logic [DATA_W-1:0] byte_val;

    alu_slice #(.DATA_W(DATA_W)) u_slice (
        .a      (a_q[DATA_W-1:0]),
        .b      (b_q[DATA_W-1:0]),
        .cin    (carry_q),
        .sub    (sub_q),
        .sum    (s_sum),
        .cout   (s_cout),
        .hout   (s_hout),
        .hw_out (s_hwout)
    );

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.result     = result_q;
    assign bus.next_flags = flags_q;
    assign bus.op_err     = err_q;

    // Map the incoming op onto adder operands: INC/DEC(W) work on op_B with a constant 1.
    always_comb begin
        eff_a   = bus.op_A;
        eff_b   = bus.op_B;
        eff_sub = 1'b0;
        eff_cin = 1'b0;
        case (bus.op_code)
            ADC: eff_cin = bus.curr_flags[FLG_C];
            SUB, CP: eff_sub = 1'b1;
            SBC: begin
                eff_sub = 1'b1;
                eff_cin = bus.curr_flags[FLG_C];
            end
            INC, INCW: begin
                eff_a = bus.op_B;
                eff_b = WORD_W'(1);
            end
            DEC, DECW: begin
                eff_a   = bus.op_B;
                eff_b   = WORD_W'(1);
                eff_sub = 1'b1;
            end
            ADDSP: eff_b = {{(WORD_W-DATA_W){bus.op_B[DATA_W-1]}}, bus.op_B[DATA_W-1:0]};
            default: ;
        endcase
    end

    // Result and flag assembly from the slice currently in the adder (used on the last slice).
    always_comb begin
        last_slice = is_word_op(op_q) ? (cnt_q == CNT_W'(NSLICE - 1)) : 1'b1;
        // ADDSP flags come from slice 0, which may be the current slice or already registered
        lo_h       = (cnt_q == '0) ? s_hout : lo_h_q;
        lo_c       = (cnt_q == '0) ? s_cout : lo_c_q;
        byte_val   = s_sum;
        fin_flags  = fin_q;
        fin_err    = 1'b0;
        fin_res    = '0;
        case (op_q)
            ADD, ADC: fin_flags = pack_flags(s_sum == '0, 1'b0, s_hout, s_cout);
            SUB, SBC: fin_flags = pack_flags(s_sum == '0, 1'b1, s_hout, s_cout);
            CP: begin
                byte_val  = a_q[DATA_W-1:0];
                fin_flags = pack_flags(s_sum == '0, 1'b1, s_hout, s_cout);
            end
            INC: fin_flags = pack_flags(s_sum == '0, 1'b0, s_hout, fin_q[FLG_C]);
            DEC: fin_flags = pack_flags(s_sum == '0, 1'b1, s_hout, fin_q[FLG_C]);
            AND: begin
                byte_val  = a_q[DATA_W-1:0] & b_q[DATA_W-1:0];
                fin_flags = pack_flags(byte_val == '0, 1'b0, 1'b1, 1'b0);
            end
            OR: begin
                byte_val  = a_q[DATA_W-1:0] | b_q[DATA_W-1:0];
                fin_flags = pack_flags(byte_val == '0, 1'b0, 1'b0, 1'b0);
            end
            XOR: begin
                byte_val  = a_q[DATA_W-1:0] ^ b_q[DATA_W-1:0];
                fin_flags = pack_flags(byte_val == '0, 1'b0, 1'b0, 1'b0);
            end
            ADDW:  fin_flags = pack_flags(fin_q[FLG_Z], 1'b0, s_hwout, s_cout);
            ADDSP: fin_flags = pack_flags(1'b0, 1'b0, lo_h, lo_c);
            INCW, DECW: fin_flags = fin_q;
            default: begin
                byte_val = '0;
                fin_err  = 1'b1;
            end
        endcase
        if (is_word_op(op_q)) begin
            fin_res = {s_sum, acc_q[WORD_W-1:DATA_W]};
        end else begin
            fin_res[DATA_W-1:0] = byte_val;
        end
    end

    // FSM next state plus operand/partial-result shift registers.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        fin_d    = fin_q;
        flags_d  = flags_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        lo_h_d   = lo_h_q;
        lo_c_d   = lo_c_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.op_code;
                    a_d     = eff_a;
                    b_d     = eff_b;
                    sub_d   = eff_sub;
                    carry_d = eff_cin;
                    fin_d   = bus.curr_flags;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = s_cout;
                acc_d   = {s_sum, acc_q[WORD_W-1:DATA_W]};
                a_d     = a_q >> DATA_W;
                b_d     = b_q >> DATA_W;
                if (cnt_q == '0) begin
                    lo_h_d = s_hout;
                    lo_c_d = s_cout;
                end
                if (last_slice) begin
                    result_d = fin_res;
                    flags_d  = fin_flags;
                    err_d    = fin_err;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            fin_q    <= '0;
            flags_q  <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            lo_h_q   <= 1'b0;
            lo_c_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            fin_q    <= fin_d;
            flags_q  <= flags_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            lo_h_q   <= lo_h_d;
            lo_c_q   <= lo_c_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against a behavioural flag/result model.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int DW = 8;
    localparam int NS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_alu_if #(.DATA_W(DW), .NSLICE(NS)) bus();
    seq_alu #(.DATA_W(DW), .NSLICE(NS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] exp_res;
    logic [3:0]  exp_flags;
    logic        exp_err;
    logic        exp_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Flags packed {Z,N,H,C}; plain integer arithmetic on the whole operand values.
    function automatic void model(input seq_alu_op_t op, input logic [15:0] A, input logic [15:0] B,
                                  input logic [3:0] F, output logic [15:0] r, output logic [3:0] fl,
                                  output logic e, output int nsl);
        int a8, b8, ci, s, off;
        logic z, n, h, cy;
        a8 = int'(A[7:0]);
        b8 = int'(B[7:0]);
        ci = int'(F[0]);
        z = F[3]; n = F[2]; h = F[1]; cy = F[0];
        r = 16'h0; e = 1'b0; nsl = 1;
        case (op)
            ADD, ADC: begin
                if (op == ADD) ci = 0;
                s = a8 + b8 + ci;
                r = 16'(s & 255); z = ((s & 255) == 0); n = 0;
                h = ((a8 & 15) + (b8 & 15) + ci) > 15; cy = s > 255;
            end
            SUB, SBC, CP: begin
                if (op != SBC) ci = 0;
                s = a8 - b8 - ci;
                r = (op == CP) ? 16'(a8) : 16'(s & 255);
                z = ((s & 255) == 0); n = 1;
                h = ((a8 & 15) - (b8 & 15) - ci) < 0; cy = s < 0;
            end
            INC: begin
                s = b8 + 1; r = 16'(s & 255); z = ((s & 255) == 0); n = 0; h = (b8 & 15) == 15;
            end
            DEC: begin
                s = b8 - 1; r = 16'(s & 255); z = ((s & 255) == 0); n = 1; h = (b8 & 15) == 0;
            end
            AND: begin r = 16'(a8 & b8); z = (r == 0); n = 0; h = 1; cy = 0; end
            OR:  begin r = 16'(a8 | b8); z = (r == 0); n = 0; h = 0; cy = 0; end
            XOR: begin r = 16'(a8 ^ b8); z = (r == 0); n = 0; h = 0; cy = 0; end
            ADDW: begin
                s = int'(A) + int'(B); r = 16'(s & 'hFFFF); n = 0;
                h = ((int'(A) & 'hFFF) + (int'(B) & 'hFFF)) > 'hFFF; cy = s > 'hFFFF; nsl = NS;
            end
            ADDSP: begin
                off = (b8 > 127) ? b8 - 256 : b8;
                r = 16'((int'(A) + off) & 'hFFFF); z = 0; n = 0;
                h = ((int'(A) & 15) + (b8 & 15)) > 15; cy = ((int'(A) & 255) + b8) > 255; nsl = NS;
            end
            INCW: begin r = 16'((int'(B) + 1) & 'hFFFF); nsl = NS; end
            DECW: begin r = 16'((int'(B) + 'hFFFF) & 'hFFFF); nsl = NS; end
            default: begin r = 16'h0; e = 1'b1; end
        endcase
        fl = {z, n, h, cy};
    endfunction

    // Every cycle a result is presented it must equal the expectation of the accepted op.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (!exp_pending) begin
                check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                check("result", 32'(bus.result), 32'(exp_res));
                check("flags", 32'(bus.next_flags), 32'(exp_flags));
                check("op_err", 32'(bus.op_err), 32'(exp_err));
            end
        end
    end

    task automatic scramble();
        bus.in_valid   = 1'($urandom_range(0, 1));
        bus.op_code    = seq_alu_op_t'(4'($urandom_range(0, 15)));
        bus.op_A       = 16'($urandom);
        bus.op_B       = 16'($urandom);
        bus.curr_flags = 4'($urandom);
    endtask

    task automatic run_op(input seq_alu_op_t op, input logic [15:0] A, input logic [15:0] B,
                          input logic [3:0] F, input int hold, input bit pinned,
                          input logic [15:0] want_r, input logic [3:0] want_f);
        logic [15:0] mr;
        logic [3:0]  mf;
        logic        me;
        int          nsl, k, lat;
        model(op, A, B, F, mr, mf, me, nsl);
        if (pinned) begin
            check("model_pin_result", 32'(mr), 32'(want_r));
            check("model_pin_flags", 32'(mf), 32'(want_f));
            mr = want_r;
            mf = want_f;
        end
        k = 0;
        while (!bus.in_ready && k < 10) begin
            @(posedge clk); #1; k++;
        end
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        exp_res = mr; exp_flags = mf; exp_err = me; exp_pending = 1'b1;
        bus.in_valid = 1'b1; bus.op_code = op; bus.op_A = A; bus.op_B = B; bus.curr_flags = F;
        @(posedge clk); #1;
        scramble();
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++; scramble();
        end
        check("latency", 32'(lat), 32'(nsl));
        repeat (hold) begin
            @(posedge clk); #1; scramble();
            check("held_out_valid", 32'(bus.out_valid), 32'd1);
            check("held_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        exp_pending   = 1'b0;
        check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
        check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", 32'(bus.next_flags), 32'd0);
        check("rst_op_err", 32'(bus.op_err), 32'd0);
    endtask

    initial begin
        seq_alu_op_t rop;
        logic [15:0] ra, rb;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op_code = ADD;
        bus.op_A = '0; bus.op_B = '0; bus.curr_flags = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_values();

        run_op(ADD,   16'h003A, 16'h00C6, 4'h0, 0, 1, 16'h0000, 4'hB);
        run_op(SBC,   16'h0010, 16'h0001, 4'h1, 1, 1, 16'h000E, 4'h6);
        run_op(ADDW,  16'h0FFF, 16'h0001, 4'h8, 0, 1, 16'h1000, 4'hA);
        run_op(ADDSP, 16'h00FF, 16'h00FF, 4'h0, 2, 1, 16'h00FE, 4'h3);
        run_op(INCW,  16'hFFFF, 16'hFFFF, 4'h5, 5, 1, 16'h0000, 4'h5);
        run_op(DECW,  16'h0000, 16'h0000, 4'hA, 0, 1, 16'hFFFF, 4'hA);
        run_op(CP,    16'h0042, 16'h0042, 4'h0, 0, 1, 16'h0042, 4'hC);
        run_op(seq_alu_op_t'(4'd15), 16'h1234, 16'h5678, 4'h7, 1, 1, 16'h0000, 4'h7);

        // Abort a word op mid-flight: the partial result must vanish.
        bus.in_valid = 1'b1; bus.op_code = ADDW; bus.op_A = 16'h1111; bus.op_B = 16'h2222;
        bus.curr_flags = 4'h0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values();
        repeat (4) begin
            @(posedge clk); #1;
            check("no_valid_after_abort", 32'(bus.out_valid), 32'd0);
        end
        run_op(XOR, 16'h00FF, 16'h00FF, 4'h0, 0, 1, 16'h0000, 4'h8);

        for (int i = 0; i < 250; i++) begin
            rop = seq_alu_op_t'(4'($urandom_range(0, 15)));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            if (rop == INCW || rop == DECW) ra = rb;
            run_op(rop, ra, rb, 4'($urandom), int'($urandom_range(0, 3)), 0, 16'h0, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
